// File: rtl/sap_pkg.sv
// Shared definitions for the 8-bit bus computer control path: opcode
// encodings, the 16-line control word in bus order and helpers.
package sap_pkg;

   localparam int OPC_SIZE = 4;

   localparam logic [OPC_SIZE-1:0] OP_NOP = 4'b0000;
   localparam logic [OPC_SIZE-1:0] OP_LDA = 4'b0001;
   localparam logic [OPC_SIZE-1:0] OP_ADD = 4'b0010;
   localparam logic [OPC_SIZE-1:0] OP_SUB = 4'b0011;
   localparam logic [OPC_SIZE-1:0] OP_STA = 4'b0100;
   localparam logic [OPC_SIZE-1:0] OP_LDI = 4'b0101;
   localparam logic [OPC_SIZE-1:0] OP_JMP = 4'b0110;
   localparam logic [OPC_SIZE-1:0] OP_JC  = 4'b0111;
   localparam logic [OPC_SIZE-1:0] OP_JZ  = 4'b1000;
   localparam logic [OPC_SIZE-1:0] OP_OUT = 4'b1110;
   localparam logic [OPC_SIZE-1:0] OP_HLT = 4'b1111;

   // Control lines in bus order, hlt is the most significant bit.
   typedef struct packed {
      logic hlt;
      logic mi;
      logic ri;
      logic ro;
      logic io;
      logic ii;
      logic ai;
      logic ao;
      logic eo;
      logic su;
      logic bi;
      logic oi;
      logic ce;
      logic co;
      logic j;
      logic fi;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = ctrl_t'(16'h0000);

   // Opcodes with no execute phase (NOP and every unassigned encoding)
   // end the instruction at T1.
   function automatic logic op_is_fetch_only(input logic [OPC_SIZE-1:0] op);
      logic r;
      case (op)
         OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
         OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: r = 1'b0;
         default:                              r = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/control_sequencer_microcode_rom.sv
// Combinational microcode store: maps (microstep, opcode, flags) to the
// control word for that step and whether it is the instruction's last step.
module microcode_rom
   import sap_pkg::*;
#(
   parameter int STEP_BITS = 3
) (
   input  logic [STEP_BITS-1:0] step_i,
   input  logic [OPC_SIZE-1:0]  ir_op_i,
   input  logic                 cf_i,
   input  logic                 zf_i,
   output ctrl_t                word_o,
   output logic                 last_o
);

   localparam logic [STEP_BITS-1:0] T0 = STEP_BITS'(0);
   localparam logic [STEP_BITS-1:0] T1 = STEP_BITS'(1);
   localparam logic [STEP_BITS-1:0] T2 = STEP_BITS'(2);
   localparam logic [STEP_BITS-1:0] T3 = STEP_BITS'(3);
   localparam logic [STEP_BITS-1:0] T4 = STEP_BITS'(4);

   ctrl_t word_s;
   logic  last_s;

   // Decode one microstep of the current instruction into control lines.
   always_comb begin
      word_s = CTRL_NONE;
      last_s = 1'b0;
      case (step_i)
         T0: begin
            word_s.co = 1'b1;
            word_s.mi = 1'b1;
         end
         T1: begin
            word_s.ro = 1'b1;
            word_s.ii = 1'b1;
            word_s.ce = 1'b1;
            last_s    = op_is_fetch_only(ir_op_i);
         end
         T2: begin
            case (ir_op_i)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  word_s.io = 1'b1;
                  word_s.mi = 1'b1;
               end
               OP_LDI: begin
                  word_s.io = 1'b1;
                  word_s.ai = 1'b1;
                  last_s    = 1'b1;
               end
               OP_JMP: begin
                  word_s.io = 1'b1;
                  word_s.j  = 1'b1;
                  last_s    = 1'b1;
               end
               OP_JC: begin
                  // Carry is taken as presented now; a not-taken jump is an empty step.
                  if (cf_i) begin
                     word_s.io = 1'b1;
                     word_s.j  = 1'b1;
                  end else begin
                     word_s = CTRL_NONE;
                  end
                  last_s = 1'b1;
               end
               OP_JZ: begin
                  if (zf_i) begin
                     word_s.io = 1'b1;
                     word_s.j  = 1'b1;
                  end else begin
                     word_s = CTRL_NONE;
                  end
                  last_s = 1'b1;
               end
               OP_OUT: begin
                  word_s.ao = 1'b1;
                  word_s.oi = 1'b1;
                  last_s    = 1'b1;
               end
               OP_HLT: begin
                  word_s.hlt = 1'b1;
                  last_s     = 1'b1;
               end
               default: begin
                  last_s = 1'b1;
               end
            endcase
         end
         T3: begin
            case (ir_op_i)
               OP_LDA: begin
                  word_s.ro = 1'b1;
                  word_s.ai = 1'b1;
                  last_s    = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  word_s.ro = 1'b1;
                  word_s.bi = 1'b1;
               end
               OP_STA: begin
                  word_s.ao = 1'b1;
                  word_s.ri = 1'b1;
                  last_s    = 1'b1;
               end
               default: begin
                  last_s = 1'b1;
               end
            endcase
         end
         T4: begin
            case (ir_op_i)
               OP_ADD: begin
                  word_s.eo = 1'b1;
                  word_s.ai = 1'b1;
                  word_s.fi = 1'b1;
               end
               OP_SUB: begin
                  word_s.eo = 1'b1;
                  word_s.su = 1'b1;
                  word_s.ai = 1'b1;
                  word_s.fi = 1'b1;
               end
               default: begin
                  word_s = CTRL_NONE;
               end
            endcase
            last_s = 1'b1;
         end
         default: begin
            // Unreachable step values: emit nothing and return to T0.
            last_s = 1'b1;
         end
      endcase
   end

   assign word_o = word_s;
   assign last_o = last_s;

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control unit: steps the T-state counter on the falling clock
// edge, holds the halt latch, applies the reset/prog/halt overrides and
// drives the 16 active-high control lines for the datapath.
module control_sequencer
   import sap_pkg::*;
#(
   parameter int OPC_SIZE_P = OPC_SIZE,
   parameter int STEPS      = 5,
   parameter int STEP_BITS  = 3
) (
   input  logic                  clk,
   input  logic                  clr_,
   input  logic                  prog,
   input  logic [OPC_SIZE_P-1:0] ir_op,
   input  logic                  cf,
   input  logic                  zf,
   output logic                  hlt,
   output logic                  mi,
   output logic                  ri,
   output logic                  ro,
   output logic                  io,
   output logic                  ii,
   output logic                  ai,
   output logic                  ao,
   output logic                  eo,
   output logic                  su,
   output logic                  bi,
   output logic                  oi,
   output logic                  ce,
   output logic                  co,
   output logic                  j,
   output logic                  fi,
   output logic [STEP_BITS-1:0]  step,
   output logic                  halted
);

   localparam logic [STEP_BITS-1:0] STEP_ZERO = STEP_BITS'(0);
   localparam logic [STEP_BITS-1:0] STEP_ONE  = STEP_BITS'(1);

   logic [STEP_BITS-1:0] step_q;
   logic [STEP_BITS-1:0] step_d;
   logic                 halted_q;
   logic                 halted_d;
   ctrl_t                rom_word_s;
   logic                 rom_last_s;
   logic                 step_oob_s;
   ctrl_t                ctrl_s;

   microcode_rom #(
      .STEP_BITS (STEP_BITS)
   ) u_rom (
      .step_i  (step_q),
      .ir_op_i (ir_op[OPC_SIZE-1:0]),
      .cf_i    (cf),
      .zf_i    (zf),
      .word_o  (rom_word_s),
      .last_o  (rom_last_s)
   );

   assign step_oob_s = (int'(step_q) >= STEPS);

   // Next microstep and halt latch; prog beats halt, halt freezes the step.
   always_comb begin
      step_d   = step_q;
      halted_d = halted_q;
      if (prog) begin
         step_d = STEP_ZERO;
      end else if (halted_q) begin
         step_d = step_q;
      end else if (step_oob_s) begin
         step_d = STEP_ZERO;
      end else if (rom_word_s.hlt) begin
         // Halt takes effect on this edge and leaves the step where it is.
         halted_d = 1'b1;
      end else if (rom_last_s) begin
         step_d = STEP_ZERO;
      end else begin
         step_d = step_q + STEP_ONE;
      end
   end

   // State updates on the falling edge so the decode settles before the datapath's rising edge.
   always_ff @(negedge clk or negedge clr_) begin
      if (!clr_) begin
         step_q   <= STEP_ZERO;
         halted_q <= 1'b0;
      end else begin
         step_q   <= step_d;
         halted_q <= halted_d;
      end
   end

   // Output override: reset shows the T0 decode, then prog, then halt, then microcode.
   always_comb begin
      ctrl_s = CTRL_NONE;
      if (!clr_) begin
         ctrl_s.co = 1'b1;
         ctrl_s.mi = 1'b1;
      end else if (prog) begin
         ctrl_s = CTRL_NONE;
      end else if (halted_q) begin
         ctrl_s.hlt = 1'b1;
      end else begin
         ctrl_s = rom_word_s;
      end
   end

   assign hlt    = ctrl_s.hlt;
   assign mi     = ctrl_s.mi;
   assign ri     = ctrl_s.ri;
   assign ro     = ctrl_s.ro;
   assign io     = ctrl_s.io;
   assign ii     = ctrl_s.ii;
   assign ai     = ctrl_s.ai;
   assign ao     = ctrl_s.ao;
   assign eo     = ctrl_s.eo;
   assign su     = ctrl_s.su;
   assign bi     = ctrl_s.bi;
   assign oi     = ctrl_s.oi;
   assign ce     = ctrl_s.ce;
   assign co     = ctrl_s.co;
   assign j      = ctrl_s.j;
   assign fi     = ctrl_s.fi;
   assign step   = step_q;
   assign halted = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios with literal control words,
// then randomized opcodes/flags/prog/reset against a table-driven model.
module tb_control_sequencer;

   localparam logic [15:0] L_HLT = 16'h8000;
   localparam logic [15:0] L_MI  = 16'h4000;
   localparam logic [15:0] L_RI  = 16'h2000;
   localparam logic [15:0] L_RO  = 16'h1000;
   localparam logic [15:0] L_IO  = 16'h0800;
   localparam logic [15:0] L_II  = 16'h0400;
   localparam logic [15:0] L_AI  = 16'h0200;
   localparam logic [15:0] L_AO  = 16'h0100;
   localparam logic [15:0] L_EO  = 16'h0080;
   localparam logic [15:0] L_SU  = 16'h0040;
   localparam logic [15:0] L_BI  = 16'h0020;
   localparam logic [15:0] L_OI  = 16'h0010;
   localparam logic [15:0] L_CE  = 16'h0008;
   localparam logic [15:0] L_CO  = 16'h0004;
   localparam logic [15:0] L_J   = 16'h0002;
   localparam logic [15:0] L_FI  = 16'h0001;

   logic       clk   = 1'b0;
   logic       clr_  = 1'b1;
   logic       prog  = 1'b0;
   logic [3:0] ir_op = 4'd0;
   logic       cf    = 1'b0;
   logic       zf    = 1'b0;
   logic hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi;
   logic [2:0] step;
   logic       halted;
   logic [15:0] dut_ctrl;

   int n_checks = 0;
   int n_pass   = 0;

   // Model: microprogram per opcode (list of step words) and its length.
   logic [15:0] uprog [16][5];
   int          ulen  [16];
   int          m_step = 0;
   logic        m_halt = 1'b0;

   control_sequencer dut (
      .clk(clk), .clr_(clr_), .prog(prog), .ir_op(ir_op), .cf(cf), .zf(zf),
      .hlt(hlt), .mi(mi), .ri(ri), .ro(ro), .io(io), .ii(ii), .ai(ai), .ao(ao),
      .eo(eo), .su(su), .bi(bi), .oi(oi), .ce(ce), .co(co), .j(j), .fi(fi),
      .step(step), .halted(halted)
   );

   assign dut_ctrl = {hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi};

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic check_lit(input string name, input int s, input logic h, input logic [15:0] w);
      check({name, "_ctrl"}, dut_ctrl, w);
      check({name, "_step"}, {13'd0, step}, 16'(s));
      check({name, "_halt"}, {15'd0, halted}, {15'd0, h});
   endtask

   task automatic cyc();
      @(negedge clk);
      #2;
   endtask

   initial begin
      for (int o = 0; o < 16; o++) begin
         ulen[o] = 2;
         for (int s = 0; s < 5; s++) uprog[o][s] = 16'h0000;
         uprog[o][0] = L_CO | L_MI;
         uprog[o][1] = L_RO | L_II | L_CE;
      end
      ulen[1]  = 4; uprog[1][2]  = L_IO | L_MI; uprog[1][3] = L_RO | L_AI;
      ulen[2]  = 5; uprog[2][2]  = L_IO | L_MI; uprog[2][3] = L_RO | L_BI;
      uprog[2][4] = L_EO | L_AI | L_FI;
      ulen[3]  = 5; uprog[3][2]  = L_IO | L_MI; uprog[3][3] = L_RO | L_BI;
      uprog[3][4] = L_EO | L_SU | L_AI | L_FI;
      ulen[4]  = 4; uprog[4][2]  = L_IO | L_MI; uprog[4][3] = L_AO | L_RI;
      ulen[5]  = 3; uprog[5][2]  = L_IO | L_AI;
      ulen[6]  = 3; uprog[6][2]  = L_IO | L_J;
      ulen[7]  = 3; uprog[7][2]  = L_IO | L_J;
      ulen[8]  = 3; uprog[8][2]  = L_IO | L_J;
      ulen[14] = 3; uprog[14][2] = L_AO | L_OI;
      ulen[15] = 3; uprog[15][2] = L_HLT;
   end

   function automatic logic [15:0] model_ctrl();
      logic [15:0] w;
      if (!clr_) return L_CO | L_MI;
      if (prog) return 16'h0000;
      if (m_halt) return L_HLT;
      w = uprog[ir_op][m_step];
      if (m_step == 2 && ((ir_op == 4'd7 && !cf) || (ir_op == 4'd8 && !zf))) w = 16'h0000;
      return w;
   endfunction

   // Model state advance on the falling edge, reset asynchronously.
   always @(negedge clk or negedge clr_) begin
      if (!clr_) begin
         m_step <= 0;
         m_halt <= 1'b0;
      end else if (prog) begin
         m_step <= 0;
      end else if (m_halt) begin
         m_step <= m_step;
      end else if (ir_op == 4'd15 && m_step == 2) begin
         m_halt <= 1'b1;
      end else begin
         m_step <= (m_step + 1) % ulen[ir_op];
      end
   end

   // Compare every rising edge, where the datapath would capture.
   always @(posedge clk) begin
      check("model_ctrl", dut_ctrl, model_ctrl());
      check("model_step", {13'd0, step}, 16'(m_step));
      check("model_halt", {15'd0, halted}, {15'd0, m_halt});
   end

   initial begin
      #1 clr_ = 1'b0;
      // 1: reset then NOP fetch loop
      repeat (3) cyc();
      check_lit("rst", 0, 1'b0, 16'h4004);
      prog = 1'b1; #1;
      check_lit("rst_prog", 0, 1'b0, 16'h4004);
      prog = 1'b0;
      clr_ = 1'b1; #1;
      check_lit("nop_t0", 0, 1'b0, 16'h4004);
      cyc(); check_lit("nop_t1", 1, 1'b0, 16'h1408);
      cyc(); check_lit("nop_wrap", 0, 1'b0, 16'h4004);
      // 2: SUB
      ir_op = 4'd3;
      cyc(); check_lit("sub_t1", 1, 1'b0, 16'h1408);
      cyc(); check_lit("sub_t2", 2, 1'b0, 16'h4800);
      cyc(); check_lit("sub_t3", 3, 1'b0, 16'h1020);
      cyc(); check_lit("sub_t4", 4, 1'b0, 16'h02C1);
      cyc(); check_lit("sub_wrap", 0, 1'b0, 16'h4004);
      // 3: JC taken and not taken
      ir_op = 4'd7; cf = 1'b1;
      cyc(); cyc(); check_lit("jc_taken", 2, 1'b0, 16'h0802);
      cyc(); check_lit("jc_taken_end", 0, 1'b0, 16'h4004);
      cf = 1'b0;
      cyc(); cyc(); check_lit("jc_not", 2, 1'b0, 16'h0000);
      cyc(); check_lit("jc_not_end", 0, 1'b0, 16'h4004);
      // 4: HLT
      ir_op = 4'd15;
      cyc(); cyc(); check_lit("hlt_t2", 2, 1'b0, 16'h8000);
      for (int k = 0; k < 10; k++) begin
         cyc(); check_lit("halted", 2, 1'b1, 16'h8000);
      end
      clr_ = 1'b0; #1;
      check_lit("hlt_clr", 0, 1'b0, 16'h4004);
      clr_ = 1'b1;
      // 5: prog during ADD T3
      ir_op = 4'd2;
      cyc(); cyc(); cyc(); check_lit("add_t3", 3, 1'b0, 16'h1020);
      prog = 1'b1; #1;
      check_lit("prog_now", 3, 1'b0, 16'h0000);
      cyc(); check_lit("prog_edge", 0, 1'b0, 16'h0000);
      prog = 1'b0; #1;
      check_lit("prog_drop", 0, 1'b0, 16'h4004);
      cyc(); check_lit("prog_resume", 1, 1'b0, 16'h1408);
      // 6: async reset during LDA T2
      ir_op = 4'd1;
      cyc(); check_lit("lda_t2", 2, 1'b0, 16'h4800);
      clr_ = 1'b0; #1;
      check_lit("lda_async_clr", 0, 1'b0, 16'h4004);
      clr_ = 1'b1;
      // Randomized phase
      for (int n = 0; n < 3000; n++) begin
         cyc();
         if (m_halt && $urandom_range(0, 3) == 0) begin
            clr_ = 1'b0; #1; clr_ = 1'b1;
         end
         prog = ($urandom_range(0, 15) == 0);
         cf   = 1'($urandom_range(0, 1));
         zf   = 1'($urandom_range(0, 1));
         if (m_step == 0) ir_op = 4'($urandom_range(0, 15));
      end
      cyc();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
